// File: rtl/instr_loader.sv
// Instruction-memory loader: fills imem from a valid/ready word stream, then releases the CPU.
// Build option: LOADER_CHECKSUM_EN (the s_last word becomes a checksum of the data words).
// Ports: clk, reset (async, active-high), start (load request pulse),
//   s_valid/s_ready/s_data/s_last (input word stream),
//   mem_we/mem_addr/mem_wdata (imem write port), cpu_hold (CPU reset hold),
//   busy/done/error (load status), word_count (data words written in this load).
module instr_loader #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DONE, S_ERROR, S_CHECK
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_LOAD, S_DONE, S_ERROR
    } state_t;
`endif

    // word_count doubles as the write pointer; FULL means DEPTH words stored.
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   count_q, count_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              match_q, match_d;
`endif

    assign s_ready    = (state_q == S_LOAD);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = count_q;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        count_d     = count_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        match_d     = match_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    count_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            S_LOAD: begin
                if (s_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    // Checksum word is compared, never stored or counted.
                    if (s_last) begin
                        state_d = S_CHECK;
                        match_d = (sum_q == s_data);
                    end else
`endif
                    if (count_q == FULL) begin
                        // Image larger than memory: drop word, abort.
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = s_data;
                        count_d     = count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_d       = sum_q + s_data;
`else
                        if (s_last) begin
                            state_d    = S_DONE;
                            done_d     = 1'b1;
                            cpu_hold_d = 1'b0;
                            busy_d     = 1'b0;
                        end
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                busy_d = 1'b0;
                if (match_q) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
            match_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            count_q     <= count_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            match_q     <= match_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: scoreboard of expected imem writes plus per-scenario status checks.
// Checksum scenario runs only when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [18:0] s_data;
    logic        s_last;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    typedef struct {
        logic [9:0]  a;
        logic [18:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_addr = 0;

    instr_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed write must match the oldest expected one, one cycle after its handshake.
    task automatic scoreboard_monitor();
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write addr=%0d data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d || cyc != mon_e.c) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 mem_addr, mem_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
                    end
                end
            end
        end
    endtask

    task automatic send_word(input logic [18:0] d, input logic last, input bit push);
        int n;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout s_ready=%b want 1", s_ready);
        end else if (push) begin
            sb.push_back('{10'(exp_addr), d, cyc + 1});
            exp_addr++;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_hold, s_ready, mem_we, done, error, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags hold/rdy/we/done/err/busy=%b want 100000",
                     {cpu_hold, s_ready, mem_we, done, error, busy});
        end
        checks++;
        if (word_count !== 11'd0 || mem_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_count wc=%0d addr=%0d want 0 0", word_count, mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        exp_addr = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || cpu_hold !== 1'b1 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL basic_start busy=%b rdy=%b hold=%b wc=%0d want 1 1 1 0",
                     busy, s_ready, cpu_hold, word_count);
        end
        send_word(19'h00001, 1'b0, 1'b1);
        send_word(19'h7FFFF, 1'b0, 1'b1);
        send_word(19'h12345, 1'b1, 1'b1);
        checks++;
        if ({mem_we, done, cpu_hold, busy, s_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL basic_done we/done/hold/busy/rdy=%b want 11000",
                     {mem_we, done, cpu_hold, busy, s_ready});
        end
        checks++;
        if (word_count !== 11'd3) begin
            errors++;
            $display("FAIL basic_count wc=%0d want 3", word_count);
        end
        idle(4);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold done=%b hold=%b we=%b want 1 0 0", done, cpu_hold, mem_we);
        end
    endtask

    task automatic test_gaps();
        logic [18:0] img [3];
        img[0] = 19'h00001;
        img[1] = 19'h7FFFF;
        img[2] = 19'h12345;
        exp_addr = 0;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            idle($urandom_range(0, 3));
            send_word(img[i], i == 2, 1'b1);
            if (i == 0) begin
                pulse_start();
                checks++;
                if (word_count !== 11'd1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gaps_start_ignored wc=%0d busy=%b want 1 1", word_count, busy);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 11'd3) begin
            errors++;
            $display("FAIL gaps_done done=%b hold=%b wc=%0d want 1 0 3", done, cpu_hold, word_count);
        end
    endtask

    task automatic test_overflow();
        exp_addr = 0;
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            send_word(19'(i * 7 + 5), 1'b0, 1'b1);
        end
        checks++;
        if (word_count !== 11'd1024 || s_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full wc=%0d rdy=%b err=%b done=%b want 1024 1 0 0",
                     word_count, s_ready, error, done);
        end
        send_word(19'h55555, 1'b0, 1'b0);
        checks++;
        if ({error, s_ready, cpu_hold, busy, done, mem_we} !== 6'b101000) begin
            errors++;
            $display("FAIL ovf_error err/rdy/hold/busy/done/we=%b want 101000",
                     {error, s_ready, cpu_hold, busy, done, mem_we});
        end
        checks++;
        if (word_count !== 11'd1024) begin
            errors++;
            $display("FAIL ovf_count wc=%0d want 1024", word_count);
        end
        idle(3);
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL ovf_hold err=%b hold=%b we=%b want 1 1 0", error, cpu_hold, mem_we);
        end
    endtask

    task automatic test_reset_midload();
        exp_addr = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_word(19'(100 + i), 1'b0, 1'b1);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({cpu_hold, s_ready, mem_we, done, error, busy} !== 6'b100000 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL midreset hold/rdy/we/done/err/busy=%b wc=%0d want 100000 0",
                     {cpu_hold, s_ready, mem_we, done, error, busy}, word_count);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_addr = 0;
        pulse_start();
        send_word(19'h0ABCD, 1'b0, 1'b1);
        send_word(19'h3C3C3, 1'b1, 1'b1);
        checks++;
        if (done !== 1'b1 || word_count !== 11'd2 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reload done=%b wc=%0d hold=%b want 1 2 0", done, word_count, cpu_hold);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            exp_addr = 0;
            pulse_start();
            send_word(19'd1, 1'b0, 1'b1);
            send_word(19'd2, 1'b0, 1'b1);
            send_word(19'(3 + k), 1'b1, 1'b0);
            checks++;
            if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL ck_check%0d done=%b err=%b busy=%b we=%b want 0 0 1 0",
                         k, done, error, busy, mem_we);
            end
            idle(1);
            checks++;
            if (done !== (k == 0) || error !== (k == 1) || cpu_hold !== (k == 1) || word_count !== 11'd2) begin
                errors++;
                $display("FAIL ck_result%0d done=%b err=%b hold=%b wc=%0d want %b %b %b 2",
                         k, done, error, cpu_hold, word_count, k == 0, k == 1, k == 1);
            end
        end
    endtask
`endif

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
`ifndef LOADER_CHECKSUM_EN
        test_basic();
        test_gaps();
        test_overflow();
        test_reset_midload();
`else
        test_checksum();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes pending=%0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
